// File: rtl/uart16550_pkg.sv
// Register map, LSR bit positions and bridge FSM states for the 16550-style UART register port.
package uart16550_pkg;

  localparam logic [2:0] ADDR_RBR_THR = 3'd0;
  localparam logic [2:0] ADDR_DLL     = 3'd0;
  localparam logic [2:0] ADDR_IER_DLM = 3'd1;
  localparam logic [2:0] ADDR_FCR     = 3'd2;
  localparam logic [2:0] ADDR_LCR     = 3'd3;
  localparam logic [2:0] ADDR_LSR     = 3'd5;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_THRE = 5;

  localparam logic [7:0] LCR_DLAB = 8'h80;

  typedef enum logic [3:0] {
    INIT_DLAB,
    INIT_DLL,
    INIT_DLM,
    INIT_LCR,
    INIT_FCR,
    INIT_IER,
    POLL,
    WAIT_LSR,
    READ,
    WAIT_RBR,
    WRITE
  } state_t;

  // Baud divisor for 16x oversampling, rounded to nearest.
  function automatic logic [15:0] calc_div(input int clk_hz, input int baud);
    int q;
    q = (clk_hz + 8 * baud) / (16 * baud);
    return q[15:0];
  endfunction

endpackage

// File: rtl/uart_hold_reg.sv
// One-entry holding register: push wins over pop so a same-edge refill keeps it full.
module uart_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Occupancy and payload of the single entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_push) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (r_full && i_pop) begin
      r_full <= 1'b0;
    end else begin
      r_full <= r_full;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/uart_stream_bridge.sv
// Initialises a 16550-style UART register port, then polls LSR to move bytes
// between the UART IP and a pair of valid/ready streams.
module uart_stream_bridge
  import uart16550_pkg::*;
#(
  parameter int         CLK_HZ     = 27_000_000,
  parameter int         BAUD       = 115_200,
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] LCR_VAL    = 8'h03,
  parameter bit         FIFO_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       o_tx_en,
  output logic [2:0] o_waddr,
  output logic [7:0] o_wdata,
  output logic       o_rx_en,
  output logic [2:0] o_raddr,
  input  logic [7:0] i_rdata,
  input  logic       s_tx_valid,
  output logic       s_tx_ready,
  input  logic [7:0] s_tx_data,
  output logic       m_rx_valid,
  input  logic       m_rx_ready,
  output logic [7:0] m_rx_data,
  output logic       o_init_done,
  output logic       o_overrun
);

  localparam logic [15:0] DIV     = calc_div(CLK_HZ, BAUD);
  localparam logic [7:0]  FCR_VAL = FIFO_EN ? 8'h07 : 8'h00;
  localparam logic [1:0]  LAT     = 2'(RD_LATENCY);

  state_t     r_state;
  logic       r_tx_en;
  logic       r_rx_en;
  logic [2:0] r_waddr;
  logic [2:0] r_raddr;
  logic [7:0] r_wdata;
  logic [1:0] r_wait;
  logic       r_thre;
  logic       r_init_done;
  logic       r_overrun;

  logic       w_tx_full;
  logic [7:0] w_tx_data;
  logic       w_tx_pop;
  logic       w_tx_ready;
  logic       w_tx_push;
  logic       w_rx_full;
  logic       w_rx_push;

  // THR write in flight frees the tx slot early so a new byte can land on the same edge.
  assign w_tx_pop   = (r_state == WRITE);
  assign w_tx_ready = r_init_done && (!w_tx_full || w_tx_pop);
  assign w_tx_push  = s_tx_valid && w_tx_ready;
  assign w_rx_push  = (r_state == WAIT_RBR) && (r_wait == 2'd0);

  uart_hold_reg #(.WIDTH(8)) u_tx_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_tx_push),
    .i_data (s_tx_data),
    .i_pop  (w_tx_pop),
    .o_full (w_tx_full),
    .o_data (w_tx_data)
  );

  uart_hold_reg #(.WIDTH(8)) u_rx_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_rx_push),
    .i_data (i_rdata),
    .i_pop  (m_rx_ready),
    .o_full (w_rx_full),
    .o_data (m_rx_data)
  );

  // Sequencer: init writes, LSR polling, RBR reads and THR writes, one strobe at a time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= INIT_DLAB;
      r_tx_en     <= 1'b0;
      r_rx_en     <= 1'b0;
      r_waddr     <= 3'd0;
      r_raddr     <= 3'd0;
      r_wdata     <= 8'h00;
      r_wait      <= 2'd0;
      r_thre      <= 1'b0;
      r_init_done <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tx_en   <= 1'b0;
      r_rx_en   <= 1'b0;
      r_waddr   <= 3'd0;
      r_raddr   <= 3'd0;
      r_wdata   <= 8'h00;
      r_overrun <= 1'b0;
      case (r_state)
        INIT_DLAB: begin
          r_tx_en <= 1'b1; r_waddr <= ADDR_LCR;     r_wdata <= LCR_DLAB;   r_state <= INIT_DLL;
        end
        INIT_DLL: begin
          r_tx_en <= 1'b1; r_waddr <= ADDR_DLL;     r_wdata <= DIV[7:0];   r_state <= INIT_DLM;
        end
        INIT_DLM: begin
          r_tx_en <= 1'b1; r_waddr <= ADDR_IER_DLM; r_wdata <= DIV[15:8];  r_state <= INIT_LCR;
        end
        INIT_LCR: begin
          r_tx_en <= 1'b1; r_waddr <= ADDR_LCR;     r_wdata <= LCR_VAL;    r_state <= INIT_FCR;
        end
        INIT_FCR: begin
          r_tx_en <= 1'b1; r_waddr <= ADDR_FCR;     r_wdata <= FCR_VAL;    r_state <= INIT_IER;
        end
        INIT_IER: begin
          r_tx_en <= 1'b1; r_waddr <= ADDR_IER_DLM; r_wdata <= 8'h00;      r_state <= POLL;
        end
        POLL: begin
          r_init_done <= 1'b1;
          r_rx_en     <= 1'b1;
          r_raddr     <= ADDR_LSR;
          r_wait      <= LAT;
          r_state     <= WAIT_LSR;
        end
        WAIT_LSR: begin
          if (r_wait != 2'd0) begin
            r_wait <= r_wait - 2'd1;
          end else begin
            r_thre    <= i_rdata[LSR_THRE];
            r_overrun <= i_rdata[LSR_OE];
            if (i_rdata[LSR_DR] && !w_rx_full) begin
              r_state <= READ;
            end else if (i_rdata[LSR_THRE] && w_tx_full) begin
              r_state <= WRITE;
            end else begin
              r_state <= POLL;
            end
          end
        end
        READ: begin
          r_rx_en <= 1'b1;
          r_raddr <= ADDR_RBR_THR;
          r_wait  <= LAT;
          r_state <= WAIT_RBR;
        end
        WAIT_RBR: begin
          if (r_wait != 2'd0) begin
            r_wait <= r_wait - 2'd1;
          end else if (r_thre && w_tx_full) begin
            r_state <= WRITE;
          end else begin
            r_state <= POLL;
          end
        end
        WRITE: begin
          r_tx_en <= 1'b1;
          r_waddr <= ADDR_RBR_THR;
          r_wdata <= w_tx_data;
          r_state <= POLL;
        end
        default: begin
          r_state <= INIT_DLAB;
        end
      endcase
    end
  end

  assign o_tx_en     = r_tx_en;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_rx_en     = r_rx_en;
  assign o_raddr     = r_raddr;
  assign s_tx_ready  = w_tx_ready;
  assign m_rx_valid  = w_rx_full;
  assign o_init_done = r_init_done;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Bench for uart_stream_bridge: UART register-file model plus write/rx scoreboards.
module tb_uart_stream_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       o_tx_en;
  logic [2:0] o_waddr;
  logic [7:0] o_wdata;
  logic       o_rx_en;
  logic [2:0] o_raddr;
  logic [7:0] i_rdata = 8'h00;
  logic       s_tx_valid = 1'b0;
  logic       s_tx_ready;
  logic [7:0] s_tx_data = 8'h00;
  logic       m_rx_valid;
  logic       m_rx_ready = 1'b0;
  logic [7:0] m_rx_data;
  logic       o_init_done;
  logic       o_overrun;

  localparam int EV_NONE = 0;
  localparam int EV_LSR  = 1;
  localparam int EV_RBR  = 2;
  localparam int EV_WR   = 3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  fifo[$];
  logic        m_thre = 1'b0;
  logic        m_oe   = 1'b0;

  int cyc = 0, wr_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  int rbr_cnt = 0, ov_cnt = 0, ov_long = 0, rx_hs = 0;
  int prev_evt = EV_NONE, prev_at_thr = EV_NONE;
  logic prev_ov = 1'b0;

  uart_stream_bridge #(
    .CLK_HZ(27_000_000), .BAUD(115_200), .RD_LATENCY(1), .LCR_VAL(8'h03), .FIFO_EN(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .o_tx_en(o_tx_en), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .o_rx_en(o_rx_en), .o_raddr(o_raddr), .i_rdata(i_rdata),
    .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready), .s_tx_data(s_tx_data),
    .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready), .m_rx_data(m_rx_data),
    .o_init_done(o_init_done), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART IP register model, read latency 1; LSR read clears OE, RBR read pops the rx FIFO.
  always @(posedge clk) begin
    if (o_rx_en) begin
      if (o_raddr == 3'd5) begin
        i_rdata <= {2'b00, m_thre, 3'b000, m_oe, (fifo.size() != 0)};
        m_oe = 1'b0;
      end else if (o_raddr == 3'd0 && fifo.size() != 0) begin
        i_rdata <= fifo.pop_front();
      end else begin
        i_rdata <= 8'h00;
      end
    end
  end

  // Monitor sampled on the inactive edge.
  always @(negedge clk) begin
    cyc++;
    if (o_tx_en || o_rx_en) chk("strobe_excl", {31'd0, o_tx_en & o_rx_en}, 32'd0);
    if (o_tx_en) begin
      if (wr_cnt == 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      wr_cnt++;
      if (wq.size() != 0) chk("wr", {21'd0, o_waddr, o_wdata}, {21'd0, wq.pop_front()});
      else chk("wr_unexpected_q", wq.size(), 32'd1);
      if (o_waddr == 3'd0) prev_at_thr = prev_evt;
      prev_evt = EV_WR;
    end
    if (o_rx_en && o_raddr == 3'd5) prev_evt = EV_LSR;
    if (o_rx_en && o_raddr == 3'd0) begin
      prev_evt = EV_RBR;
      rbr_cnt++;
    end
    if (o_overrun) ov_cnt++;
    if (o_overrun && prev_ov) ov_long++;
    prev_ov = o_overrun;
    if (m_rx_valid && m_rx_ready) begin
      rx_hs++;
      if (rq.size() != 0) chk("rx_data", {24'd0, m_rx_data}, {24'd0, rq.pop_front()});
      else chk("rx_unexpected_q", rq.size(), 32'd1);
    end
  end

  task automatic push_init;
    wq.push_back({3'd3, 8'h80}); wq.push_back({3'd0, 8'h0F}); wq.push_back({3'd1, 8'h00});
    wq.push_back({3'd3, 8'h03}); wq.push_back({3'd2, 8'h07}); wq.push_back({3'd1, 8'h00});
  endtask

  task automatic send_tx(input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    s_tx_valid = 1'b1; s_tx_data = d;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_tx_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    s_tx_valid = 1'b0;
    chk("tx_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int wr0;
    logic seen;
    // Reset state and init sequence
    push_init();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {4'd0, o_tx_en, o_rx_en, o_waddr, o_wdata, o_raddr, s_tx_ready,
                          m_rx_valid, m_rx_data, o_init_done, o_overrun}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_init_done) break;
    end
    chk("t1_init_done", {31'd0, o_init_done}, 32'd1);
    chk("t1_wr_count", wr_cnt, 32'd6);
    chk("t1_consecutive", last_wr_cyc - first_wr_cyc, 32'd5);
    chk("t1_wq_empty", wq.size(), 32'd0);

    // Rx back-pressure: second byte stays in the IP until the consumer is ready
    @(posedge clk); #1;
    rbr_cnt = 0;
    fifo.push_back(8'h41); fifo.push_back(8'h42);
    rq.push_back(8'h41);   rq.push_back(8'h42);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_rx_valid) break;
    end
    chk("t2_rx_valid", {31'd0, m_rx_valid}, 32'd1);
    chk("t2_rx_data", {24'd0, m_rx_data}, 32'h41);
    wait_cycles(30);
    chk("t2_single_read", rbr_cnt, 32'd1);
    chk("t2_still_valid", {31'd0, m_rx_valid}, 32'd1);
    @(posedge clk); #1 m_rx_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rx_hs == 2) break;
    end
    chk("t2_rx_count", rx_hs, 32'd2);
    chk("t2_read_count", rbr_cnt, 32'd2);

    // Single THR write; ready drops after accept and returns after the write
    @(posedge clk); #1 m_thre = 1'b1;
    wr0 = wr_cnt;
    wq.push_back({3'd0, 8'h5A});
    send_tx(8'h5A);
    @(negedge clk);
    chk("t3_ready_low", {31'd0, s_tx_ready}, 32'd0);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_tx_ready) break;
    end
    chk("t3_ready_back", {31'd0, s_tx_ready}, 32'd1);
    wait_cycles(20);
    chk("t3_one_write", wr_cnt - wr0, 32'd1);
    chk("t3_prev_lsr", prev_at_thr, EV_LSR);

    // DR and THRE together: RBR read directly followed by THR write
    @(posedge clk); #1 m_thre = 1'b0;
    wait_cycles(10);
    send_tx(8'h33);
    wait_cycles(10);
    wr0 = wr_cnt;
    prev_at_thr = EV_NONE;
    wq.push_back({3'd0, 8'h33});
    rq.push_back(8'hC3);
    @(posedge clk); #1;
    fifo.push_back(8'hC3); m_thre = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr_cnt != wr0) break;
    end
    chk("t4_rbr_then_thr", prev_at_thr, EV_RBR);
    wait_cycles(10);
    chk("t4_rq_empty", rq.size(), 32'd0);
    chk("t4_wq_empty", wq.size(), 32'd0);

    // Overrun flag: single-cycle pulse, byte still delivered
    ov_cnt = 0; ov_long = 0;
    rq.push_back(8'h81);
    @(posedge clk); #1;
    m_oe = 1'b1; fifo.push_back(8'h81);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rq.size() == 0) break;
    end
    chk("t5_byte_delivered", rq.size(), 32'd0);
    wait_cycles(10);
    chk("t5_ov_pulses", ov_cnt, 32'd1);
    chk("t5_ov_single_cycle", ov_long, 32'd0);

    // Reset during WAIT_RBR with a tx byte held
    @(posedge clk); #1;
    m_thre = 1'b0; m_rx_ready = 1'b0;
    send_tx(8'h77);
    @(posedge clk); #1 fifo.push_back(8'h99);
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_rx_en && o_raddr == 3'd0) begin seen = 1'b1; break; end
    end
    chk("t6_rbr_strobe", {31'd0, seen}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_outputs", {4'd0, o_tx_en, o_rx_en, o_waddr, o_wdata, o_raddr, s_tx_ready,
                             m_rx_valid, m_rx_data, o_init_done, o_overrun}, 32'd0);
    fifo.delete();
    wr_cnt = 0;
    push_init();
    @(posedge clk); #1;
    m_thre = 1'b1; rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (o_init_done) break;
    end
    chk("t6_init_done", {31'd0, o_init_done}, 32'd1);
    chk("t6_init_writes", wr_cnt, 32'd6);
    wait_cycles(30);
    chk("t6_no_stale_tx", wr_cnt, 32'd6);
    chk("t6_wq_empty", wq.size(), 32'd0);
    chk("t6_tx_ready", {31'd0, s_tx_ready}, 32'd1);
    chk("t6_rx_empty", {31'd0, m_rx_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
